// File: rtl/axi2mem_pkg.sv
// Shared types for the axi2mem command arbiter: FSM states and the per-lane command record.
// Pure definitions; no latency or flow control of its own.
package axi2mem_pkg;

   localparam int CMD_LANES  = 2;
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_ID_W   = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_LOCK = 2'd1,
      WR_LOCK = 2'd2
   } arb_state_e;

   // wen uses TCDM polarity: 1 = read, 0 = write
   typedef struct packed {
      logic [CMD_ADDR_W-1:0] add;
      logic [3:0]            be;
      logic [CMD_ID_W-1:0]   id;
      logic                  last;
      logic                  wen;
   } cmd_lane_t;

   // A beat only moves when both lanes request and both lanes are available.
   function automatic logic is_xfer(input logic [CMD_LANES-1:0] req,
                                    input logic [CMD_LANES-1:0] gnt);
      return (req == 2'b11) && (gnt == 2'b11);
   endfunction

endpackage

// File: rtl/axi2mem_cmd_arbiter_if.sv
// Read channel, write channel and TCDM command-queue signals of the arbiter in one bundle.
// slave = arbiter view, master = the surrounding channels and queue.
interface axi2mem_cmd_arbiter_if
   import axi2mem_pkg::*;
#(
   parameter int ID_WIDTH   = 6,
   parameter int ADDR_WIDTH = 32
);

   logic [CMD_LANES-1:0]                 rd_req_i;
   logic [CMD_LANES-1:0][ADDR_WIDTH-1:0] rd_add_i;
   logic [CMD_LANES-1:0][3:0]            rd_be_i;
   logic [CMD_LANES-1:0][ID_WIDTH-1:0]   rd_id_i;
   logic [CMD_LANES-1:0]                 rd_last_i;
   logic [CMD_LANES-1:0]                 rd_gnt_o;

   logic [CMD_LANES-1:0]                 wr_req_i;
   logic [CMD_LANES-1:0][ADDR_WIDTH-1:0] wr_add_i;
   logic [CMD_LANES-1:0][3:0]            wr_be_i;
   logic [CMD_LANES-1:0][ID_WIDTH-1:0]   wr_id_i;
   logic [CMD_LANES-1:0]                 wr_last_i;
   logic [CMD_LANES-1:0]                 wr_gnt_o;

   logic [CMD_LANES-1:0]                 cmd_req_o;
   logic [CMD_LANES-1:0][ADDR_WIDTH-1:0] cmd_add_o;
   logic [CMD_LANES-1:0][3:0]            cmd_be_o;
   logic [CMD_LANES-1:0][ID_WIDTH-1:0]   cmd_id_o;
   logic [CMD_LANES-1:0]                 cmd_last_o;
   logic [CMD_LANES-1:0]                 cmd_wen_o;
   logic [CMD_LANES-1:0]                 cmd_gnt_i;

   modport slave (
      input  rd_req_i, rd_add_i, rd_be_i, rd_id_i, rd_last_i,
      output rd_gnt_o,
      input  wr_req_i, wr_add_i, wr_be_i, wr_id_i, wr_last_i,
      output wr_gnt_o,
      output cmd_req_o, cmd_add_o, cmd_be_o, cmd_id_o, cmd_last_o, cmd_wen_o,
      input  cmd_gnt_i
   );

   modport master (
      output rd_req_i, rd_add_i, rd_be_i, rd_id_i, rd_last_i,
      input  rd_gnt_o,
      output wr_req_i, wr_add_i, wr_be_i, wr_id_i, wr_last_i,
      input  wr_gnt_o,
      input  cmd_req_o, cmd_add_o, cmd_be_o, cmd_id_o, cmd_last_o, cmd_wen_o,
      output cmd_gnt_i
   );

endinterface

// File: rtl/axi2mem_cmd_mux.sv
// 2:1 lane mux selecting the read (sel=0) or write (sel=1) command record.
// Combinational, zero latency; no flow control.
module axi2mem_cmd_mux
   import axi2mem_pkg::*;
(
   input  logic                        sel,
   input  cmd_lane_t [CMD_LANES-1:0]   rd_lane,
   input  cmd_lane_t [CMD_LANES-1:0]   wr_lane,
   output cmd_lane_t [CMD_LANES-1:0]   out_lane
);

   assign out_lane = sel ? wr_lane : rd_lane;

endmodule

// File: rtl/axi2mem_cmd_arbiter.sv
// Burst-locked round-robin share of the 2-lane TCDM command queue between read and write channels.
// Zero-latency combinational path; backpressure by forwarding cmd_gnt_i only to the owning channel.
module axi2mem_cmd_arbiter
   import axi2mem_pkg::*;
#(
   parameter int ID_WIDTH   = 6,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WAIT   = 15
)(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   axi2mem_cmd_arbiter_if.slave   bus
);

   localparam int            CW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
   localparam bit            WAIT_EN  = (MAX_WAIT > 0);

   arb_state_e state_q, state_d;
   logic       rr_q, rr_d;
   // index 0 = read channel, 1 = write channel
   logic [1:0][CW-1:0] wait_cnt_q, wait_cnt_d;

   logic                      sel;
   logic                      rd_pend, wr_pend;
   logic                      force_rd, force_wr;
   logic [CMD_LANES-1:0]      sel_req;
   logic [CMD_LANES-1:0]      gnt_exp;
   logic [CMD_LANES-1:0]      cmd_req;
   logic                      xfer, xfer_last;
   logic [1:0]                pend_vec;
   cmd_lane_t [CMD_LANES-1:0] rd_lane, wr_lane, mux_lane;

   always_comb begin
      rd_lane = '0;
      wr_lane = '0;
      for (int i = 0; i < CMD_LANES; i++) begin
         rd_lane[i] = '{add:  CMD_ADDR_W'(bus.rd_add_i[i]),
                        be:   bus.rd_be_i[i],
                        id:   CMD_ID_W'(bus.rd_id_i[i]),
                        last: bus.rd_last_i[i],
                        wen:  1'b1};
         wr_lane[i] = '{add:  CMD_ADDR_W'(bus.wr_add_i[i]),
                        be:   bus.wr_be_i[i],
                        id:   CMD_ID_W'(bus.wr_id_i[i]),
                        last: bus.wr_last_i[i],
                        wen:  1'b0};
      end
   end

   axi2mem_cmd_mux u_mux (
      .sel      (sel),
      .rd_lane  (rd_lane),
      .wr_lane  (wr_lane),
      .out_lane (mux_lane)
   );

   assign rd_pend  = |bus.rd_req_i;
   assign wr_pend  = |bus.wr_req_i;
   assign pend_vec = {wr_pend, rd_pend};
   assign force_rd = WAIT_EN && rd_pend && (wait_cnt_q[0] == WAIT_MAX);
   assign force_wr = WAIT_EN && wr_pend && (wait_cnt_q[1] == WAIT_MAX);

   // Owner selection: locked channel, else lone requester, else starvation force, else round robin.
   always_comb begin
      sel = rr_q;
      case (state_q)
         RD_LOCK: sel = 1'b0;
         WR_LOCK: sel = 1'b1;
         default: begin
            if (rd_pend && !wr_pend)         sel = 1'b0;
            else if (wr_pend && !rd_pend)    sel = 1'b1;
            else if (force_rd && !force_wr)  sel = 1'b0;
            else if (force_wr && !force_rd)  sel = 1'b1;
            else                             sel = rr_q;
         end
      endcase
   end

   // Outside a burst a partially available queue is hidden, so a new burst never starts on one lane.
   always_comb begin
      sel_req = sel ? bus.wr_req_i : bus.rd_req_i;
      gnt_exp = bus.cmd_gnt_i;
      if ((state_q == IDLE) && (bus.cmd_gnt_i != 2'b11))
         gnt_exp = '0;
      cmd_req   = sel_req & gnt_exp;
      xfer      = is_xfer(sel_req, gnt_exp);
      xfer_last = mux_lane[0].last | mux_lane[1].last;
   end

   always_comb begin
      bus.rd_gnt_o   = '0;
      bus.wr_gnt_o   = '0;
      bus.cmd_req_o  = '0;
      bus.cmd_add_o  = '0;
      bus.cmd_be_o   = '0;
      bus.cmd_id_o   = '0;
      bus.cmd_last_o = '0;
      bus.cmd_wen_o  = '1;
      if (rst_ni) begin
         if (sel) bus.wr_gnt_o = gnt_exp;
         else     bus.rd_gnt_o = gnt_exp;
         bus.cmd_req_o = cmd_req;
         for (int i = 0; i < CMD_LANES; i++) begin
            bus.cmd_add_o[i]  = ADDR_WIDTH'(mux_lane[i].add);
            bus.cmd_be_o[i]   = mux_lane[i].be;
            bus.cmd_id_o[i]   = ID_WIDTH'(mux_lane[i].id);
            bus.cmd_last_o[i] = mux_lane[i].last;
            bus.cmd_wen_o[i]  = mux_lane[i].wen;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (xfer_last) rr_d    = ~rr_q;
               else           state_d = sel ? WR_LOCK : RD_LOCK;
            end
         end
         RD_LOCK, WR_LOCK: begin
            if (xfer && xfer_last) begin
               state_d = IDLE;
               rr_d    = ~sel;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (WAIT_EN) begin
         for (int c = 0; c < 2; c++) begin
            if (xfer && (sel == 1'(c)))
               wait_cnt_d[c] = '0;
            else if (pend_vec[c] && (sel != 1'(c)) && (wait_cnt_q[c] != WAIT_MAX))
               wait_cnt_d[c] = wait_cnt_q[c] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         rr_q       <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Lanes always move together; a one-lane request from the owner is a channel bug.
   lane_match_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(sel_req inside {2'b01, 2'b10}));

endmodule
